// File: rtl/memory_block_reader.sv
// Block reader: walks a BLK_W x BLK_H pixel block out of a single-port synchronous RAM in
// row-major order and streams the pixels through a 4-entry FIFO with a valid/ready handshake.
module memory_block_reader #(
  parameter int unsigned AWIDTH = 12,
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned BLK_W  = 16,
  parameter int unsigned BLK_H  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH-1:0] stride,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] mem_address,
  output logic              mem_wren,
  output logic [DWIDTH-1:0] mem_data,
  input  logic [DWIDTH-1:0] mem_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last
);

  localparam logic [8:0] ColMax = 9'(BLK_W - 1);
  localparam logic [8:0] RowMax = 9'(BLK_H - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [AWIDTH-1:0] row_base_q, row_base_d;
  logic [AWIDTH-1:0] stride_q, stride_d;
  logic [8:0]        col_q, col_d, row_q, row_d;
  // final_q: the address currently on mem_address is the block's last pixel
  logic              final_q, final_d;
  // issued_q: a new address is on the bus this cycle; cap_q: mem_q holds read data this cycle
  logic              issued_q, issued_d;
  logic              cap_q, cap_last_q;
  logic              done_q, done_d;

  logic [DWIDTH-1:0] fifo_data_q [4];
  logic [3:0]        fifo_last_q;
  logic [1:0]        wr_ptr_q, rd_ptr_q;
  logic [2:0]        count_q;
  logic              push, pop;
  logic [3:0]        occupancy;

  assign push      = cap_q;
  assign out_valid = (count_q != 3'd0);
  assign pop       = out_valid && out_ready;
  // FIFO entries plus reads still in the RAM pipeline; bounds issue so the FIFO cannot overflow
  assign occupancy = {1'b0, count_q} + {3'b000, issued_q} + {3'b000, cap_q};

  // Next-state, address generation and done pulse
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    row_base_d = row_base_q;
    stride_d   = stride_q;
    col_d      = col_q;
    row_d      = row_q;
    final_d    = final_q;
    issued_d   = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // The done cycle is already IDLE but must not accept a new block
        if (start && !done_q) begin
          state_d    = StRead;
          addr_d     = base_addr;
          row_base_d = base_addr;
          stride_d   = stride;
          col_d      = 9'd0;
          row_d      = 9'd0;
          issued_d   = 1'b1;
          final_d    = (ColMax == 9'd0) && (RowMax == 9'd0);
        end
      end
      StRead: begin
        if (final_q) begin
          state_d = StDrain;
        end else if (occupancy < 4'd4) begin
          issued_d = 1'b1;
          if (col_q == ColMax) begin
            row_base_d = row_base_q + stride_q;
            addr_d     = row_base_q + stride_q;
            col_d      = 9'd0;
            row_d      = row_q + 9'd1;
          end else begin
            addr_d = addr_q + 1'b1;
            col_d  = col_q + 9'd1;
          end
          final_d = (row_d == RowMax) && (col_d == ColMax);
        end
      end
      StDrain: begin
        if (pop && fifo_last_q[rd_ptr_q]) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and address registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      row_base_q <= '0;
      stride_q   <= '0;
      col_q      <= 9'd0;
      row_q      <= 9'd0;
      final_q    <= 1'b0;
      issued_q   <= 1'b0;
      cap_q      <= 1'b0;
      cap_last_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      stride_q   <= stride_d;
      col_q      <= col_d;
      row_q      <= row_d;
      final_q    <= final_d;
      issued_q   <= issued_d;
      cap_q      <= issued_q;
      cap_last_q <= issued_q && final_q;
      done_q     <= done_d;
    end
  end

  // Output FIFO: captures mem_q one cycle after its address was issued
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) fifo_data_q[i] <= '0;
      fifo_last_q <= 4'b0000;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= mem_q;
        fifo_last_q[wr_ptr_q] <= cap_last_q;
        wr_ptr_q              <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + {2'b00, push} - {2'b00, pop};
    end
  end

  assign out_data    = fifo_data_q[rd_ptr_q];
  assign out_last    = out_valid && fifo_last_q[rd_ptr_q];
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign mem_address = addr_q;
  assign mem_wren    = 1'b0;
  assign mem_data    = '0;

endmodule

// File: tb/tb_memory_block_reader.sv
// Bench for memory_block_reader with a 4x4 block and RAM contents word[a] = a[7:0].
module tb_memory_block_reader;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] stride = '0;
  logic          busy, done, mem_wren, out_valid, out_last;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data, out_data;
  logic [DW-1:0] mem_q = '0;
  logic          out_ready = 1'b0;

  always #5 clock = ~clock;

  memory_block_reader #(.AWIDTH(AW), .DWIDTH(DW), .BLK_W(4), .BLK_H(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr), .stride(stride),
    .busy(busy), .done(done), .mem_address(mem_address), .mem_wren(mem_wren),
    .mem_data(mem_data), .mem_q(mem_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  // Synchronous RAM model, one-cycle read latency
  always @(posedge clock) mem_q <= mem_address[7:0];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int ready_duty = 100;
  always @(posedge clock) begin
    #1;
    out_ready = (ready_duty >= 100) || (int'($urandom_range(99)) < ready_duty);
  end

  typedef struct packed {logic [7:0] d; logic l;} exp_t;
  exp_t exp_q[$];

  int pix_cnt, first_valid_cyc, done_cyc, done_cnt;
  logic [7:0] first_data, last_data, prev_data;
  logic stall_prev = 1'b0, prev_last;

  // Scoreboard: expected pixels for a whole block
  task automatic push_block(input logic [AW-1:0] b, input logic [AW-1:0] s);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        int a;
        exp_t e;
        a = (int'(b) + r * int'(s) + c) & 'hFFF;
        e.d = 8'(a);
        e.l = (r == 3) && (c == 3);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic clear_mon();
    pix_cnt = 0;
    first_valid_cyc = -1;
    done_cyc = -1;
    done_cnt = 0;
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clock) begin
    if (reset_n) begin
      if (stall_prev) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_data", int'(out_data), int'(prev_data));
        check("stall_last", int'(out_last), int'(prev_last));
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        check("pixel_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("pixel_data", int'(out_data), int'(e.d));
          check("pixel_last", int'(out_last), int'(e.l));
        end
        if (pix_cnt == 0) first_data = out_data;
        if (out_last) last_data = out_data;
        pix_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_at_done", int'(busy), 0);
      end
      stall_prev = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_last"}, int'(out_last), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_mem_address"}, int'(mem_address), 0);
    check({tag, "_mem_wren"}, int'(mem_wren), 0);
    check({tag, "_mem_data"}, int'(mem_data), 0);
  endtask

  // Pulse start for one cycle and scramble the block parameters afterwards
  task automatic start_block(input logic [AW-1:0] b, input logic [AW-1:0] s, output int sc);
    @(posedge clock);
    #1;
    base_addr = b;
    stride = s;
    start = 1'b1;
    sc = cyc;
    clear_mon();
    push_block(b, s);
    @(posedge clock);
    #1;
    start = 1'b0;
    base_addr = 12'h100;
    stride = 12'h007;
    check("addr_cycle1", int'(mem_address), int'(b));
    check("busy_cycle1", int'(busy), 1);
  endtask

  task automatic wait_done(input int limit);
    for (int k = 0; k < limit && done_cnt == 0; k++) @(posedge clock);
    #1;
    if (done_cnt == 0) check("done_timeout", done_cnt, 1);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] str;
    int            duty;
    bit            pulse_start;
    bit            timed;
    logic [7:0]    exp_first;
    logic [7:0]    exp_last;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int s, s2;
    vecs[0] = '{12'h010, 12'h040, 100, 1'b0, 1'b1, 8'h10, 8'hD3};
    vecs[1] = '{12'hFF2, 12'h040, 100, 1'b0, 1'b1, 8'hF2, 8'hB5};
    vecs[2] = '{12'h010, 12'h000, 100, 1'b0, 1'b1, 8'h10, 8'h13};
    vecs[3] = '{12'h010, 12'h040, 30, 1'b1, 1'b0, 8'h10, 8'hD3};
    clear_mon();

    #2;
    check_outputs_zero("reset");
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      ready_duty = vecs[i].duty;
      start_block(vecs[i].base, vecs[i].str, s);
      if (vecs[i].pulse_start) begin
        repeat (4) @(posedge clock);
        #1;
        start = 1'b1;
        base_addr = 12'h100;
        @(posedge clock);
        #1;
        start = 1'b0;
      end
      wait_done(2000);
      repeat (6) @(posedge clock);
      #1;
      check("vec_pixels", pix_cnt, 16);
      check("vec_done_count", done_cnt, 1);
      check("vec_first_data", int'(first_data), int'(vecs[i].exp_first));
      check("vec_last_data", int'(last_data), int'(vecs[i].exp_last));
      check("vec_queue_empty", exp_q.size(), 0);
      check("vec_idle_after", int'(busy), 0);
      if (vecs[i].timed) begin
        check("vec_first_valid_latency", first_valid_cyc - s, 3);
        check("vec_done_latency", done_cyc - s, 19);
      end
    end

    // Back-to-back: start in the done cycle is ignored, start in the next cycle is accepted
    ready_duty = 100;
    start_block(12'h010, 12'h000, s);
    for (int k = 0; k < 200 && !done; k++) begin
      @(posedge clock);
      #1;
    end
    check("b2b_done_seen", int'(done), 1);
    check("b2b_first_block_pixels", pix_cnt, 16);
    start = 1'b1;
    base_addr = 12'h200;
    stride = 12'h040;
    @(posedge clock);
    #1;
    base_addr = 12'h020;
    s2 = cyc;
    clear_mon();
    push_block(12'h020, 12'h040);
    @(posedge clock);
    #1;
    start = 1'b0;
    check("b2b_addr_cycle1", int'(mem_address), 'h020);
    wait_done(2000);
    repeat (4) @(posedge clock);
    #1;
    check("b2b_first_valid_latency", first_valid_cyc - s2, 3);
    check("b2b_pixels", pix_cnt, 16);
    check("b2b_done_count", done_cnt, 1);
    check("b2b_last_data", int'(last_data), 'hE3);

    // Reset mid-block after 5 pixels, then restart on the first edge after release
    start_block(12'h010, 12'h040, s);
    for (int k = 0; k < 200 && pix_cnt < 5; k++) @(negedge clock);
    check("mid_reset_pixels_before", pix_cnt, 5);
    #1;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    exp_q.delete();
    @(posedge clock);
    #1;
    check_outputs_zero("mid_reset_held");
    reset_n = 1'b1;
    base_addr = 12'h000;
    stride = 12'h040;
    start = 1'b1;
    s = cyc;
    clear_mon();
    push_block(12'h000, 12'h040);
    @(posedge clock);
    #1;
    start = 1'b0;
    check("post_reset_busy", int'(busy), 1);
    wait_done(2000);
    repeat (4) @(posedge clock);
    #1;
    check("post_reset_first_data", int'(first_data), 'h00);
    check("post_reset_last_data", int'(last_data), 'hC3);
    check("post_reset_first_valid_latency", first_valid_cyc - s, 3);
    check("post_reset_pixels", pix_cnt, 16);
    check("post_reset_done_count", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_block_reader.md
MEMORY_BLOCK_READER -- requirements
Module: memory_block_reader

Interface
REQ-001 Parameter AWIDTH, default 12: memory address width.
REQ-002 Parameter DWIDTH, default 8: pixel / memory data width.
REQ-003 Parameter BLK_W, default 16: pixels per block row, range 1..256.
REQ-004 Parameter BLK_H, default 16: block rows, range 1..256.
REQ-005 Port clock, input, 1: single clock, all state updates on its rising edge.
REQ-006 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 Port start, input, 1: request one block read; sampled only in IDLE.
REQ-008 Port base_addr, input, AWIDTH: address of the block's top-left pixel; sampled with start.
REQ-009 Port stride, input, AWIDTH: row pitch in words; sampled with start.
REQ-010 Port busy, output, 1: high from the cycle after start is accepted until done.
REQ-011 Port done, output, 1: one-cycle pulse at end of block.
REQ-012 Port mem_address, output, AWIDTH: address to the single-port synchronous RAM.
REQ-013 Port mem_wren, output, 1: constant 0.
REQ-014 Port mem_data, output, DWIDTH: constant 0.
REQ-015 Port mem_q, input, DWIDTH: RAM read data, valid one cycle after the address is presented.
REQ-016 Port out_valid, output, 1: out_data holds a pixel.
REQ-017 Port out_ready, input, 1: consumer accepts the pixel when out_valid and out_ready are both high.
REQ-018 Port out_data, output, DWIDTH: pixel value.
REQ-019 Port out_last, output, 1: high with the final pixel of the block.

Function
REQ-020 The block SHALL implement states IDLE, READ and DRAIN: IDLE->READ on start; READ->DRAIN after the final address issues; DRAIN->IDLE at the handshake of the final pixel.
REQ-021 Pixel (r,c) address SHALL be (base_addr + r*stride + c) mod 2^AWIDTH; carries beyond AWIDTH are discarded.
REQ-022 Addresses SHALL issue in row-major order, c fastest; BLK_W*BLK_H issues total, none repeated or skipped.
REQ-023 Timing: start high in cycle 0 (IDLE) -> mem_address=base_addr in cycle 1 -> first out_valid in cycle 3.
REQ-024 mem_q SHALL be captured into a 4-entry output FIFO one cycle after its address was issued.
REQ-025 An address SHALL issue only when registered fifo_count + inflight < 4, with inflight in 0..2; the FIFO never overflows.
REQ-026 mem_address SHALL hold its last value in cycles where no address issues.
REQ-027 With out_ready held high, throughput SHALL be 1 pixel per cycle with no bubbles after the first pixel.
REQ-028 out_data, out_valid and out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 out_valid SHALL be 0 whenever the FIFO is empty.
REQ-030 out_last SHALL be high only with pixel (BLK_H-1, BLK_W-1); for BLK_W=BLK_H=1 the only pixel carries out_last.
REQ-031 done SHALL pulse in the cycle after the out_last handshake; busy falls in that same cycle.
REQ-032 start SHALL be ignored while busy, and base_addr and stride changes SHALL have no effect mid-block.
REQ-033 start asserted in the done cycle SHALL be ignored; start in the next (IDLE) cycle SHALL be accepted.
REQ-034 stride=0 SHALL be legal: every row rereads the same addresses.

Reset
REQ-035 When reset_n=0, the block SHALL asynchronously return to IDLE and clear the FIFO, inflight counter and row/column counters.
REQ-036 Reset values: busy=0, done=0, out_valid=0, out_last=0, out_data=0, mem_address=0, mem_wren=0, mem_data=0.
REQ-037 A reset mid-block SHALL abandon the block: no further pixels, no done pulse, and data returning after release is discarded.
REQ-038 After reset_n deasserts, the first start SHALL be honoured from the first rising edge.

Verification (BLK_W=BLK_H=4, AWIDTH=12, RAM contents word[a] = a[7:0])
REQ-039 Nominal: base 0x010, stride 0x040, out_ready=1 -> addresses 0x010-0x013, 0x050-0x053, 0x090-0x093, 0x0D0-0x0D3; 16 pixels on consecutive cycles starting cycle 3; out_last with 0xD3; done pulses once.
REQ-040 Wrap: base 0xFF2, stride 0x040 -> row 0 addresses 0xFF2-0xFF5; row 1 addresses 0x032-0x035.
REQ-041 Backpressure: random out_ready at 30% duty -> identical 16-pixel sequence, no loss or duplication, out_data stable while stalled, inflight never exceeds 2, FIFO never exceeds 4.
REQ-042 Start while busy: pulse start with base 0x100 during a block -> the current block completes unchanged and no second block starts.
REQ-043 Reset mid-block: reset_n low after 5 pixels -> all outputs 0 next cycle; a fresh start with base 0x000 streams 0x00 first with no stale data.
REQ-044 Degenerate: stride=0 -> 0x10,0x11,0x12,0x13 repeated 4 times; back-to-back start in the first IDLE cycle after done -> second block begins 3 cycles later.
